trivium_stream_engine: RTL



---
 rtl/trivium_pkg.sv | 35 +++
 rtl/trivium_lfsr_core.sv | 52 +++++
 rtl/trivium_stream_engine.sv | 120 ++++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium-style stream engine: FSM states,
// LFSR init values, seed mask byte and the feedback tap masks (all taps below bit 64).
package trivium_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_READY,
    ST_GEN,
    ST_OUT
  } state_e;

  localparam logic [63:0] INIT_S1 = 64'h23A2B;
  localparam logic [63:0] INIT_S2 = 64'h2A892;
  localparam logic [63:0] INIT_S3 = 64'hF4511;

  localparam logic [7:0] SEED_MASK_BYTE = 8'hA5;

  // Tap masks: FB<n>_S<m> selects the bits of s<m> feeding the feedback of s<n>
  localparam logic [63:0] FB1_S1 = (64'd1 << 5) | (64'd1 << 31);
  localparam logic [63:0] FB1_S2 = (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 47);
  localparam logic [63:0] FB1_S3 = (64'd1 << 1) | (64'd1 << 13) | (64'd1 << 60);
  localparam logic [63:0] FB2_S1 = (64'd1 << 1) | (64'd1 << 23);
  localparam logic [63:0] FB2_S2 = (64'd1 << 2);
  localparam logic [63:0] FB2_S3 = (64'd1 << 3) | (64'd1 << 19);
  localparam logic [63:0] FB3_S1 = (64'd1 << 5) | (64'd1 << 17) | (64'd1 << 10);
  localparam logic [63:0] FB3_S2 = (64'd1 << 2) | (64'd1 << 29) | (64'd1 << 40);
  localparam logic [63:0] FB3_S3 = (64'd1 << 4) | (64'd1 << 63);

  // Output flag vector {seed_ready, in_ready, out_valid, busy} for a state
  function automatic logic [3:0] state_flags(state_e s);
    return {s == ST_IDLE, s == ST_READY, s == ST_OUT, s != ST_IDLE};
  endfunction

endpackage

// File: rtl/trivium_lfsr_core.sv
// Three coupled shift registers producing one keystream bit per step; init beats load beats step.
// z is combinational from the current (pre-step) register state.
module trivium_lfsr_core
  import trivium_pkg::*;
#(
  parameter int LFSR_LEN = 64,
  parameter int SEED_W   = 16
) (
  input  logic              clk,
  input  logic              init,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  input  logic              step,
  output logic              z
);

  logic [LFSR_LEN-1:0] r_s1, r_s2, r_s3;
  logic [SEED_W-1:0]   w_rev, w_mask;
  logic                w_fb1, w_fb2, w_fb3;

  always_comb begin
    for (int i = 0; i < SEED_W; i++) begin
      w_rev[i]  = seed[SEED_W-1-i];
      w_mask[i] = SEED_MASK_BYTE[i % 8];
    end
  end

  always_comb begin
    w_fb1 = (^(r_s1[63:0] & FB1_S1)) ^ (^(r_s2[63:0] & FB1_S2)) ^ (^(r_s3[63:0] & FB1_S3));
    w_fb2 = (^(r_s1[63:0] & FB2_S1)) ^ (^(r_s2[63:0] & FB2_S2)) ^ (^(r_s3[63:0] & FB2_S3));
    w_fb3 = (^(r_s1[63:0] & FB3_S1)) ^ (^(r_s2[63:0] & FB3_S2)) ^ (^(r_s3[63:0] & FB3_S3));
  end

  assign z = r_s1[0] ^ r_s2[0] ^ r_s3[0];

  always_ff @(posedge clk) begin
    if (init) begin
      r_s1 <= LFSR_LEN'(INIT_S1);
      r_s2 <= LFSR_LEN'(INIT_S2);
      r_s3 <= LFSR_LEN'(INIT_S3);
    end else if (load) begin
      r_s1 <= LFSR_LEN'(seed);
      r_s2 <= LFSR_LEN'(w_rev);
      r_s3 <= LFSR_LEN'(seed ^ w_mask);
    end else if (step) begin
      r_s1 <= (r_s1 << 1) | LFSR_LEN'(w_fb1);
      r_s2 <= (r_s2 << 1) | LFSR_LEN'(w_fb2);
      r_s3 <= (r_s3 << 1) | LFSR_LEN'(w_fb3);
    end
  end

endmodule

// File: rtl/trivium_stream_engine.sv
// Seeded stream cipher engine: XORs a DATA_W-bit keystream word onto each accepted word.
// out_valid DATA_W cycles after input accept; OUT holds data and keystream until out_ready.
module trivium_stream_engine
  import trivium_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LFSR_LEN   = 64,
  parameter int SEED_W     = 16,
  parameter int WARMUP_CYC = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [SEED_W-1:0] seed_data,
  output logic              seed_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              abort,
  output logic              busy
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WCW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

  state_e            r_state;
  logic [3:0]        r_flags;
  logic [WCW-1:0]    r_wcnt;
  logic [BCW-1:0]    r_bcnt;
  logic [DATA_W-1:0] r_ks, r_word, r_out_data;

  logic              w_z, w_step, w_load, w_init;
  logic [DATA_W-1:0] w_ks_nxt;

  assign w_init   = rst | abort;
  assign w_load   = (r_state == ST_IDLE) & seed_valid;
  assign w_step   = (r_state == ST_WARMUP) | (r_state == ST_GEN);
  // Earliest keystream bit ends up in the MSB of the word
  assign w_ks_nxt = (r_ks << 1) | DATA_W'(w_z);

  trivium_lfsr_core #(
    .LFSR_LEN(LFSR_LEN),
    .SEED_W  (SEED_W)
  ) u_core (
    .clk (clk),
    .init(w_init),
    .load(w_load),
    .seed(seed_data),
    .step(w_step),
    .z   (w_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_flags    <= state_flags(ST_IDLE);
      r_wcnt     <= '0;
      r_bcnt     <= '0;
      r_ks       <= '0;
      r_word     <= '0;
      r_out_data <= '0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_flags <= state_flags(ST_IDLE);
    end else begin
      case (r_state)
        ST_IDLE: if (seed_valid) begin
          r_wcnt <= '0;
          if (WARMUP_CYC == 0) begin
            r_state <= ST_READY;
            r_flags <= state_flags(ST_READY);
          end else begin
            r_state <= ST_WARMUP;
            r_flags <= state_flags(ST_WARMUP);
          end
        end
        ST_WARMUP: begin
          if (r_wcnt == WCW'(WARMUP_CYC - 1)) begin
            r_state <= ST_READY;
            r_flags <= state_flags(ST_READY);
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        ST_READY: if (in_valid) begin
          r_word  <= in_data;
          r_ks    <= '0;
          r_bcnt  <= '0;
          r_state <= ST_GEN;
          r_flags <= state_flags(ST_GEN);
        end
        ST_GEN: begin
          r_ks <= w_ks_nxt;
          if (r_bcnt == BCW'(DATA_W - 1)) begin
            r_out_data <= r_word ^ w_ks_nxt;
            r_state    <= ST_OUT;
            r_flags    <= state_flags(ST_OUT);
          end else begin
            r_bcnt <= r_bcnt + BCW'(1);
          end
        end
        ST_OUT: if (out_ready) begin
          r_state <= ST_READY;
          r_flags <= state_flags(ST_READY);
        end
        default: begin
          r_state <= ST_IDLE;
          r_flags <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

  assign {seed_ready, in_ready, out_valid, busy} = r_flags;
  assign out_data = r_out_data;

endmodule
